// File: rtl/uart_cfg.sv
// uart_cfg: configurable 8N1-style UART transmitter and receiver.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_cfg #(
  parameter int INPUT_FREQ = 5_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       txd,
  input  logic       rxd,
  input  logic [7:0] tx_data,
  input  logic       send_data,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       received_data_intr,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int DIV = (INPUT_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] MID   = CW'(DIV / 2 - 1);
  localparam logic [2:0]    DLAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    SLAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]    MASK  = 8'((1 << DATA_BITS) - 1);
  localparam logic          PODD  = 1'(PARITY_ODD);
`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t          tx_st, tx_nx;
  logic [CW-1:0]   tx_cnt, tx_cnt_nx;
  logic [2:0]      tx_idx, tx_idx_nx;
  logic [7:0]      tx_sh, tx_sh_nx;
  logic            tx_par, tx_par_nx;
  logic            tx_tick;

  assign tx_tick = (tx_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_st  <= tx_nx;
      tx_cnt <= tx_cnt_nx;
      tx_idx <= tx_idx_nx;
      tx_sh  <= tx_sh_nx;
      tx_par <= tx_par_nx;
    end
  end

  always_comb begin
    tx_nx     = tx_st;
    tx_cnt_nx = tx_tick ? '0 : tx_cnt + 1'b1;
    tx_idx_nx = tx_idx;
    tx_sh_nx  = tx_sh;
    tx_par_nx = tx_par;
    txd       = 1'b1;
    busy      = 1'b1;
    unique case (tx_st)
      S_IDLE: begin
        busy      = 1'b0;
        tx_cnt_nx = '0;
        if (send_data) begin
          tx_sh_nx  = tx_data & MASK;
          tx_par_nx = ^(tx_data & MASK) ^ PODD;
          tx_idx_nx = '0;
          tx_nx     = S_START;
        end
      end
      S_START: begin
        txd = 1'b0;
        if (tx_tick) tx_nx = S_DATA;
      end
      S_DATA: begin
        txd = tx_sh[tx_idx];
        if (tx_tick) begin
          if (tx_idx == DLAST) begin
            tx_idx_nx = '0;
            tx_nx     = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            tx_idx_nx = tx_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        txd = tx_par;
        if (tx_tick) tx_nx = S_STOP;
      end
      S_STOP: begin
        if (tx_tick) begin
          if (tx_idx == SLAST) begin
            tx_idx_nx = '0;
            tx_nx     = S_IDLE;
          end else begin
            tx_idx_nx = tx_idx + 1'b1;
          end
        end
      end
      default: tx_nx = S_IDLE;
    endcase
  end

  logic            rx_s1, rx_s2, rx_prev;
  state_t          rx_st, rx_nx;
  logic [CW-1:0]   rx_cnt, rx_cnt_nx;
  logic [2:0]      rx_idx, rx_idx_nx;
  logic [7:0]      rx_sh, rx_sh_nx;
  logic            rx_par, rx_par_nx;
  logic            rx_wait, rx_wait_nx;
  logic            rx_tick, do_ok, do_ferr, do_perr;

  assign rx_tick = (rx_cnt == ((rx_st == S_START) ? MID : LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1              <= 1'b1;
      rx_s2              <= 1'b1;
      rx_prev            <= 1'b1;
      rx_st              <= S_IDLE;
      rx_cnt             <= '0;
      rx_idx             <= '0;
      rx_sh              <= '0;
      rx_par             <= 1'b0;
      rx_wait            <= 1'b0;
      rx_data            <= '0;
      received_data_intr <= 1'b0;
      frame_err          <= 1'b0;
      parity_err         <= 1'b0;
    end else begin
      rx_s1              <= rxd;
      rx_s2              <= rx_s1;
      rx_prev            <= rx_s2;
      rx_st              <= rx_nx;
      rx_cnt             <= rx_cnt_nx;
      rx_idx             <= rx_idx_nx;
      rx_sh              <= rx_sh_nx;
      rx_par             <= rx_par_nx;
      rx_wait            <= rx_wait_nx;
      if (do_ok) rx_data <= rx_sh;
      received_data_intr <= do_ok;
      frame_err          <= do_ferr;
      parity_err         <= do_perr;
    end
  end

  always_comb begin
    rx_nx      = rx_st;
    rx_cnt_nx  = rx_tick ? '0 : rx_cnt + 1'b1;
    rx_idx_nx  = rx_idx;
    rx_sh_nx   = rx_sh;
    rx_par_nx  = rx_par;
    rx_wait_nx = rx_wait;
    do_ok      = 1'b0;
    do_ferr    = 1'b0;
    do_perr    = 1'b0;
    unique case (rx_st)
      S_IDLE: begin
        rx_cnt_nx = '0;
        rx_idx_nx = '0;
        rx_sh_nx  = '0;
        if (rx_prev && !rx_s2) rx_nx = S_START;
      end
      S_START: begin
        if (rx_tick) rx_nx = rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_sh_nx[rx_idx] = rx_s2;
          if (rx_idx == DLAST) begin
            rx_idx_nx = '0;
            rx_nx     = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            rx_idx_nx = rx_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (rx_tick) begin
          rx_par_nx = rx_s2;
          rx_nx     = S_STOP;
        end
      end
      S_STOP: begin
        // after a framing error, hold here until the line returns high
        if (rx_wait) begin
          rx_cnt_nx = '0;
          if (rx_s2) begin
            rx_wait_nx = 1'b0;
            rx_nx      = S_IDLE;
          end
        end else if (rx_tick) begin
          if (!rx_s2) begin
            do_ferr    = 1'b1;
            rx_wait_nx = 1'b1;
          end else if (PAR_EN && (rx_par != (^rx_sh ^ PODD))) begin
            do_perr = 1'b1;
            rx_nx   = S_IDLE;
          end else begin
            do_ok = 1'b1;
            rx_nx = S_IDLE;
          end
        end
      end
      default: rx_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: directed checks of uart_cfg at default parameters.
// Loopback and hand-driven rxd frames; parity checks when UART_PARITY_EN.
module tb_uart_cfg;

  localparam int DIV = 43;
`ifdef UART_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       loop = 1'b0;
  logic       rx_drv = 1'b1;
  logic [7:0] tx_data = '0;
  logic       send_data = 1'b0;
  logic       txd, rxd, busy;
  logic [7:0] rx_data;
  logic       intr, ferr, perr;

  int n_chk = 0;
  int n_pass = 0;
  int busy_cnt = 0;
  int intr_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] rx_log [0:15];

  always #5 clk = ~clk;

  assign rxd = loop ? txd : rx_drv;

  uart_cfg dut (
    .clk(clk),
    .reset(reset),
    .txd(txd),
    .rxd(rxd),
    .tx_data(tx_data),
    .send_data(send_data),
    .busy(busy),
    .rx_data(rx_data),
    .received_data_intr(intr),
    .frame_err(ferr),
    .parity_err(perr)
  );

  always @(posedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (perr) perr_cnt <= perr_cnt + 1;
    if (intr) begin
      rx_log[4'(intr_cnt)] <= rx_data;
      intr_cnt <= intr_cnt + 1;
    end
  end

`ifdef UART_PARITY_EN
  logic       p_txd, p_busy, p_intr, p_ferr, p_perr;
  logic [7:0] p_rx_data;
  logic       p_send = 1'b0;
  int p_intr_cnt = 0;
  int p_perr_cnt = 0;

  uart_cfg #(.DATA_BITS(7), .PARITY_ODD(0)) dut_p (
    .clk(clk),
    .reset(reset),
    .txd(p_txd),
    .rxd(rx_drv),
    .tx_data(tx_data),
    .send_data(p_send),
    .busy(p_busy),
    .rx_data(p_rx_data),
    .received_data_intr(p_intr),
    .frame_err(p_ferr),
    .parity_err(p_perr)
  );

  always @(posedge clk) begin
    if (p_intr) p_intr_cnt <= p_intr_cnt + 1;
    if (p_perr) p_perr_cnt <= p_perr_cnt + 1;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [15:0] mk(input logic [7:0] d,
                                     input logic stop);
`ifdef UART_PARITY_EN
    return {5'b0, stop, ^d, d, 1'b0};
`else
    return {6'b0, stop, d, 1'b0};
`endif
  endfunction

  task automatic rx_frame(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = v[i];
      repeat (DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_intr(input int base, input int n);
    for (int i = 0; i < 2000 && (intr_cnt - base) < n; i++)
      @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  task automatic tx_check(input logic [7:0] d);
    logic [15:0] v;
    int b0, i0;
    v = mk(d, 1'b1);
    b0 = busy_cnt;
    i0 = intr_cnt;
    loop = 1'b1;
    @(negedge clk);
    tx_data = d;
    send_data = 1'b1;
    @(negedge clk);
    send_data = 1'b0;
    chk("busy_rise", 32'(busy), 1);
    for (int k = 0; k < FL; k++) begin
      repeat (20) @(negedge clk);
      chk("txd_bit", 32'(txd), 32'(v[k]));
      repeat (23) @(negedge clk);
    end
    chk("busy_len", 32'(busy_cnt - b0), 32'(FL * DIV));
    wait_intr(i0, 1);
    chk("rx_pulses", 32'(intr_cnt - i0), 1);
    chk("rx_data", 32'(rx_data), 32'(d));
  endtask

  initial begin
    int i0, f0, p0;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_intr", 32'(intr), 0);
    chk("rst_ferr", 32'(ferr), 0);
    chk("rst_perr", 32'(perr), 0);
    reset = 1'b0;

    tx_check(8'hA5);

    i0 = intr_cnt;
    tx_data = 8'h00;
    send_data = 1'b1;
    @(negedge clk);
    chk("b2b_busy1", 32'(busy), 1);
    tx_data = 8'hFF;
    for (int i = 0; i < 600 && busy; i++) @(negedge clk);
    chk("b2b_gap", 32'(busy), 0);
    @(negedge clk);
    chk("b2b_start", 32'(busy), 1);
    send_data = 1'b0;
    wait_intr(i0, 2);
    chk("b2b_pulses", 32'(intr_cnt - i0), 2);
    chk("b2b_first", 32'(rx_log[4'(i0)]), 32'h00);
    chk("b2b_second", 32'(rx_log[4'(i0 + 1)]), 32'hFF);

    loop = 1'b0;
    rx_drv = 1'b1;
    repeat (10) @(negedge clk);
    i0 = intr_cnt;
    f0 = ferr_cnt;
    p0 = perr_cnt;
    rx_drv = 1'b0;
    repeat (10) @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_intr", 32'(intr_cnt - i0), 0);
    chk("glitch_ferr", 32'(ferr_cnt - f0), 0);
    chk("glitch_perr", 32'(perr_cnt - p0), 0);
    rx_frame(mk(8'h3C, 1'b1), FL);
    wait_intr(i0, 1);
    chk("post_glitch_rx", 32'(rx_data), 32'h3C);

    i0 = intr_cnt;
    f0 = ferr_cnt;
    rx_frame(mk(8'h55, 1'b0), FL - 1);
    rx_drv = 1'b0;
    repeat (DIV) @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    chk("ferr_pulse", 32'(ferr_cnt - f0), 1);
    chk("ferr_no_intr", 32'(intr_cnt - i0), 0);
    chk("ferr_rx_kept", 32'(rx_data), 32'h3C);

    loop = 1'b1;
    @(negedge clk);
    tx_data = 8'h0F;
    send_data = 1'b1;
    @(negedge clk);
    send_data = 1'b0;
    repeat (4 * DIV + 20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_txd", 32'(txd), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rx", 32'(rx_data), 0);
    repeat (5) @(negedge clk);
    tx_check(8'hC3);

`ifdef UART_PARITY_EN
    loop = 1'b0;
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    i0 = p_intr_cnt;
    p0 = p_perr_cnt;
    rx_frame({6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
    repeat (100) @(negedge clk);
    chk("par_err_pulse", 32'(p_perr_cnt - p0), 1);
    chk("par_err_no_intr", 32'(p_intr_cnt - i0), 0);
    chk("par_err_rx_kept", 32'(p_rx_data), 0);
    rx_frame({6'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10);
    repeat (100) @(negedge clk);
    chk("par_ok_intr", 32'(p_intr_cnt - i0), 1);
    chk("par_ok_rx", 32'(p_rx_data), 32'h41);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_cfg.md
UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 Parameter INPUT_FREQ, default 5_000_000, clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-004 Parameter STOP_BITS, default 1, TX stop bits, legal 1 or 2.
REQ-005 Parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity; used only when UART_PARITY_EN is defined.
REQ-006 Ports: clk input 1, sole clock; reset input 1, synchronous active-high reset.
REQ-007 Port txd output 1, serial transmit line, idle high.
REQ-008 Port rxd input 1, asynchronous serial receive line.
REQ-009 Port tx_data input 8, transmit word; bits [DATA_BITS-1:0] are used.
REQ-010 Port send_data input 1, transmit request, sampled only while busy is low.
REQ-011 Port busy output 1, high while a frame is being transmitted.
REQ-012 Port rx_data output 8, received word, zero-extended above DATA_BITS.
REQ-013 Port received_data_intr output 1, one-cycle pulse signalling that rx_data holds a new valid word.
REQ-014 Port frame_err output 1, one-cycle pulse on a bad stop bit.
REQ-015 Port parity_err output 1, one-cycle pulse on a parity mismatch; tied low without UART_PARITY_EN.

Function
REQ-016 Bit period DIV = (INPUT_FREQ + BAUD_RATE/2) / BAUD_RATE clocks; TX and RX use independent counters of width clog2(DIV+1).
REQ-017 TX FSM states are IDLE, START, DATA, PARITY, STOP; PARITY is skipped without UART_PARITY_EN.
REQ-018 In IDLE, send_data=1 latches tx_data[DATA_BITS-1:0] and causes busy=1 and txd=0 (start bit) on the next cycle.
REQ-019 Each TX bit is held for exactly DIV cycles; data is sent LSB first; stop bits are high, STOP_BITS of them.
REQ-020 busy falls on the cycle after the last stop bit completes; send_data held high then starts the next frame on that cycle, giving back-to-back frames with no idle gap.
REQ-021 send_data while busy=1 is ignored and does not alter the frame in flight.
REQ-022 rxd passes through a two-flop synchroniser before any use; the synchroniser flops reset to 1.
REQ-023 RX FSM states are IDLE, START, DATA, PARITY, STOP; PARITY is skipped without UART_PARITY_EN.
REQ-024 In IDLE, a synchronised high-to-low transition enters START; the line is sampled at DIV/2 cycles; if it is high there, the event is a glitch and the FSM returns to IDLE with no output pulse.
REQ-025 Each data, parity and stop bit is sampled DIV cycles after the previous sample; data is assembled LSB first.
REQ-026 RX checks only the first stop bit regardless of STOP_BITS.
REQ-027 Stop sample high with no parity error: rx_data updates and received_data_intr pulses, in the same cycle, one cycle after the stop sample.
REQ-028 Stop sample low: frame_err pulses, rx_data keeps its old value, no received_data_intr; the FSM returns to IDLE only after rxd is seen high.
REQ-029 Parity mismatch: parity_err pulses in the cycle where received_data_intr would have pulsed; rx_data keeps its old value and received_data_intr does not pulse.
REQ-030 TX and RX operate fully independently; loopback of txd to rxd is legal.

Reset
REQ-031 reset=1 at any clock edge forces both FSMs to IDLE and zeroes both bit counters, aborting any frame in progress.
REQ-032 Reset values: txd=1, busy=0, rx_data=0, received_data_intr=0, frame_err=0, parity_err=0.
REQ-033 After reset is released, busy stays 0 and the first send_data is accepted on the next edge.

Configuration
REQ-034 Macro UART_PARITY_EN defined: one parity bit per PARITY_ODD follows the data on TX and is checked on RX.
REQ-035 Macro UART_PARITY_EN undefined: no parity bit, parity_err is constant 0, and the frame is start, DATA_BITS data bits, then the stop bits.

Verification
REQ-036 Defaults (DIV=43), txd looped to rxd, send 8'hA5 -> txd shows 0,1,0,1,0,0,1,0,1,1 with 43 clocks per bit; received_data_intr pulses once with rx_data=8'hA5; busy is high for exactly 430 cycles.
REQ-037 Hold send_data high with 8'h00 then 8'hFF -> two frames with no idle gap; rx_data reads 8'h00 then 8'hFF.
REQ-038 Drive rxd low for 10 cycles then high -> no pulses; next valid frame 8'h3C is received correctly.
REQ-039 Send 8'h55 with the stop bit forced low -> frame_err pulses once, no received_data_intr, rx_data unchanged.
REQ-040 UART_PARITY_EN, PARITY_ODD=0, DATA_BITS=7: frame 7'h41 with the parity bit flipped -> parity_err pulses; correct parity -> rx_data=8'h41.
REQ-041 Assert reset mid-TX data bit 3 -> next cycle txd=1 and busy=0; a fresh send of 8'hC3 completes correctly.
